// File: rtl/ysyx_22051145_regfile_pkg.sv
// ysyx_22051145_regfile_pkg: shared widths and constants for the multi-port register file
package ysyx_22051145_regfile_pkg;
  localparam int XLEN_DEF = 64;
  localparam int NREG_DEF = 32;
  localparam logic [XLEN_DEF-1:0] ZERO_WORD = '0;
endpackage

// File: rtl/ysyx_22051145_regfile_sb.sv
// ysyx_22051145_regfile_sb: pending-bit scoreboard with issue reservation, write-back clear and hazard flags
import ysyx_22051145_regfile_pkg::*;
module ysyx_22051145_regfile_sb #(
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWR-1:0]    wen,
  input  logic [NWR*AW-1:0] waddr,
  input  logic [NRD*AW-1:0] raddr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_rd,
  output logic [NRD-1:0]    rbusy,
  output logic              iss_stall
);
  logic [NREG-1:0] r_pend;
  logic [NREG-1:0] w_hit;
  logic [NREG-1:0] w_set;
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NWR; i++)
      if (wen[i]) w_hit[waddr[i*AW +: AW]] = 1'b1;
  end
  assign iss_stall = iss_en && iss_rd != '0 && r_pend[iss_rd] && !(BYPASS != 0 && w_hit[iss_rd]);
  always_comb begin
    w_set = '0;
    if (iss_en && iss_rd != '0 && !iss_stall) w_set[iss_rd] = 1'b1;
  end
  // a reservation issued in the same cycle as a write-back to that register survives
  always_ff @(posedge clk or posedge rst)
    if (rst) r_pend <= '0;
    else r_pend <= ((r_pend & ~w_hit) | w_set) & ~{{(NREG-1){1'b0}}, 1'b1};
  for (genvar j = 0; j < NRD; j++) begin : g_rb
    assign rbusy[j] = r_pend[raddr[j*AW +: AW]] && !(BYPASS != 0 && w_hit[raddr[j*AW +: AW]]);
  end
endmodule

// File: rtl/ysyx_22051145_regfile_mp.sv
// ysyx_22051145_regfile_mp: multi-port register file with hardwired x0, write bypass and scoreboard
import ysyx_22051145_regfile_pkg::*;
module ysyx_22051145_regfile_mp #(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NWR-1:0]      wen,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*XLEN-1:0] wdata,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_stall,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data
);
  logic [XLEN-1:0] r_regs [NREG];
  // ascending port order makes the highest-indexed writer win
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int k = 0; k < NREG; k++) r_regs[k] <= '0;
    else
      for (int i = 0; i < NWR; i++)
        if (wen[i] && waddr[i*AW +: AW] != '0) r_regs[waddr[i*AW +: AW]] <= wdata[i*XLEN +: XLEN];
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic [AW-1:0]   w_a;
    logic [XLEN-1:0] w_v;
    assign w_a = raddr[j*AW +: AW];
    always_comb begin
      w_v = r_regs[w_a];
      if (BYPASS != 0)
        for (int i = 0; i < NWR; i++)
          if (wen[i] && waddr[i*AW +: AW] == w_a) w_v = wdata[i*XLEN +: XLEN];
    end
    assign rdata[j*XLEN +: XLEN] = (rst || w_a == '0) ? XLEN'(ZERO_WORD) : w_v;
  end
  assign dbg_data = r_regs[dbg_addr];
  ysyx_22051145_regfile_sb #(.NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(BYPASS)) u_sb (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .raddr(raddr),
    .iss_en(iss_en), .iss_rd(iss_rd), .rbusy(rbusy), .iss_stall(iss_stall)
  );
endmodule

// File: tb/tb_ysyx_22051145_regfile_mp.sv
// tb_ysyx_22051145_regfile_mp: directed and random checks against a behavioural register-file model
module tb_ysyx_22051145_regfile_mp;
  logic clk = 0, rst = 1;
  logic [1:0] wen;
  logic [9:0] waddr;
  logic [127:0] wdata;
  logic [9:0] raddr;
  logic [127:0] rdata;
  logic [1:0] rbusy;
  logic iss_en, iss_stall;
  logic [4:0] iss_rd, dbg_addr;
  logic [63:0] dbg_data;
  logic [63:0] mreg [32];
  bit [31:0] mpend;
  int n = 0, nf = 0;

  ysyx_22051145_regfile_mp dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata), .rbusy(rbusy), .iss_en(iss_en), .iss_rd(iss_rd), .iss_stall(iss_stall),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit whit(logic [4:0] a);
    bit h;
    h = 0;
    for (int i = 0; i < 2; i++) if (wen[i] && waddr[i*5 +: 5] == a) h = 1;
    return h;
  endfunction

  function automatic logic [63:0] exp_rd(logic [4:0] a);
    logic [63:0] v;
    v = mreg[a];
    for (int i = 0; i < 2; i++) if (wen[i] && waddr[i*5 +: 5] == a) v = wdata[i*64 +: 64];
    return (a == 0 || rst) ? 64'd0 : v;
  endfunction

  function automatic bit exp_stall();
    return iss_en && iss_rd != 0 && mpend[iss_rd] && !whit(iss_rd);
  endfunction

  task automatic check_all(string tag);
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("%s_rdata%0d", tag, j), rdata[j*64 +: 64], exp_rd(raddr[j*5 +: 5]));
      chk($sformatf("%s_rbusy%0d", tag, j), 64'(rbusy[j]),
          64'(mpend[raddr[j*5 +: 5]] && !whit(raddr[j*5 +: 5])));
    end
    chk({tag, "_stall"}, 64'(iss_stall), 64'(exp_stall()));
    chk({tag, "_dbg"}, dbg_data, mreg[dbg_addr]);
  endtask

  task automatic step();
    logic [63:0] nreg [32];
    bit [31:0] np;
    nreg = mreg;
    np = mpend;
    for (int i = 0; i < 2; i++)
      if (wen[i]) begin
        if (waddr[i*5 +: 5] != 0) nreg[waddr[i*5 +: 5]] = wdata[i*64 +: 64];
        np[waddr[i*5 +: 5]] = 0;
      end
    if (iss_en && iss_rd != 0 && !exp_stall()) np[iss_rd] = 1;
    np[0] = 0;
    @(posedge clk);
    #1;
    mreg = nreg;
    mpend = np;
  endtask

  task automatic idle();
    wen = 0; waddr = 0; wdata = 0; iss_en = 0; iss_rd = 0;
  endtask

  initial begin
    idle();
    raddr = 0; dbg_addr = 0;
    for (int k = 0; k < 32; k++) mreg[k] = 0;
    mpend = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 32; k++) begin
      dbg_addr = 5'(k); raddr = {5'(k), 5'(k)};
      #1;
      chk($sformatf("rst_dbg%0d", k), dbg_data, 64'd0);
      chk($sformatf("rst_rd%0d", k), rdata[63:0] | rdata[127:64], 64'd0);
      chk($sformatf("rst_busy%0d", k), 64'(rbusy), 64'd0);
    end
    rst = 0;
    // bypass of a fresh write
    wen = 2'b01; waddr = 10'd5; wdata = 128'hDEAD_BEEF; raddr = 10'd5;
    #1;
    chk("byp_rd0", rdata[63:0], 64'hDEAD_BEEF);
    step(); idle(); dbg_addr = 5;
    #1;
    chk("byp_dbg", dbg_data, 64'hDEAD_BEEF);
    // two ports to the same register, then a write to x0
    wen = 2'b11; waddr = {5'd7, 5'd7}; wdata = {64'h22, 64'h11};
    step(); idle(); raddr = 10'd7;
    #1;
    chk("dual_wr", rdata[63:0], 64'h22);
    wen = 2'b01; waddr = 10'd0; wdata = 128'h55; raddr = 10'd0; dbg_addr = 0;
    #1;
    chk("x0_rd", rdata[63:0], 64'd0);
    step(); idle();
    #1;
    chk("x0_dbg", dbg_data, 64'd0);
    // reservation, WAW stall, write-back release
    iss_en = 1; iss_rd = 3;
    #1;
    chk("iss3_nostall", 64'(iss_stall), 64'd0);
    step(); idle(); raddr = {5'd3, 5'd0};
    #1;
    chk("busy3", 64'(rbusy[1]), 64'd1);
    iss_en = 1; iss_rd = 3;
    #1;
    chk("waw3", 64'(iss_stall), 64'd1);
    step(); idle();
    wen = 2'b10; waddr = {5'd3, 5'd0}; wdata = {64'h3333, 64'd0};
    #1;
    chk("wb3_busy", 64'(rbusy[1]), 64'd0);
    chk("wb3_byp", rdata[127:64], 64'h3333);
    step(); idle();
    #1;
    chk("wb3_clear", 64'(rbusy[1]), 64'd0);
    // write and issue the same register in one cycle
    wen = 2'b01; waddr = 10'd9; wdata = 128'h99; iss_en = 1; iss_rd = 9;
    #1;
    chk("wi9_stall", 64'(iss_stall), 64'd0);
    step(); idle(); raddr = 10'd9; dbg_addr = 9;
    #1;
    chk("wi9_busy", 64'(rbusy[0]), 64'd1);
    chk("wi9_data", dbg_data, 64'h99);
    // reset mid-operation
    wen = 2'b01; waddr = 10'd4; wdata = 128'h4444;
    step(); idle(); iss_en = 1; iss_rd = 4;
    step(); idle(); iss_en = 1; iss_rd = 6;
    step(); idle(); raddr = {5'd6, 5'd4}; dbg_addr = 4;
    #1;
    check_all("pre_rst");
    #2 rst = 1;
    #1;
    chk("mid_rst_rd0", rdata[63:0], 64'd0);
    chk("mid_rst_busy", 64'(rbusy), 64'd0);
    chk("mid_rst_dbg", dbg_data, 64'd0);
    for (int k = 0; k < 32; k++) mreg[k] = 0;
    mpend = 0;
    @(posedge clk);
    #1 rst = 0;
    iss_en = 1; iss_rd = 4;
    #1;
    chk("post_rst_iss4", 64'(iss_stall), 64'd0);
    step(); idle();
    // random traffic with collisions concentrated on low registers
    for (int c = 0; c < 400; c++) begin
      wen = 2'($urandom);
      for (int i = 0; i < 2; i++) begin
        waddr[i*5 +: 5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
        wdata[i*64 +: 64] = {$urandom, $urandom};
        raddr[i*5 +: 5] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      end
      iss_en = 1'($urandom);
      iss_rd = 5'($urandom_range(0, 7));
      dbg_addr = 5'($urandom_range(0, 7));
      #1;
      check_all($sformatf("rnd%0d", c));
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n, nf);
    $finish;
  end
endmodule
